dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter ADDR_W, default 11, dmem word-index width; byte-address window is 2^(ADDR_W+2) bytes.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 req_valid  in  1  request presented by the pipeline.
REQ-005 req_ready  out  1  block accepts a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  in  1  load sign-extend (byte/half only).
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data; right-aligned for byte/half.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-013 resp_err  out  1  request rejected (misaligned, illegal size, out of range).
REQ-014 dmem_we  out  1  write strobe to dmem.
REQ-015 dmem_addr  out  ADDR_W  dmem word index.
REQ-016 dmem_wdata  out  32  full word written to dmem.
REQ-017 dmem_rdata  in  32  dmem combinational read data for dmem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE with rst low.
REQ-019 Acceptance SHALL occur when req_valid && req_ready; all request fields are latched; the word index is req_addr[ADDR_W+1:2].
REQ-020 Error SHALL be flagged when size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:ADDR_W+2]!=0; the path is IDLE->RESP with resp_err=1, and dmem_we is never asserted.
REQ-021 Load path: IDLE->READ->RESP; in READ the selected lane of dmem_rdata is extracted and extended, then registered.
REQ-022 Word store path: IDLE->WRITE->RESP; dmem_wdata = latched wdata.
REQ-023 Byte/half store path: IDLE->READ->WRITE->RESP; READ latches dmem_rdata; WRITE writes that word with only the addressed lane replaced.
REQ-024 Lanes SHALL be little-endian: byte n = bits[8n+7:8n] for addr[1:0]=n; half k = bits[16k+15:16k] for addr[1]=k.
REQ-025 dmem_we SHALL be 1 exactly for the single WRITE cycle.
REQ-026 dmem_addr SHALL hold the latched index from acceptance until the next acceptance.
REQ-027 resp_valid SHALL be 1 for exactly the RESP cycle; RESP->IDLE unconditionally; no backpressure on the response.
REQ-028 Latency from acceptance to resp_valid SHALL be: load 2, word store 2, sub-word store 3, error 1 cycles.
REQ-029 resp_rdata and resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-030 Unsigned loads SHALL zero-extend; req_signed SHALL be ignored for word loads and stores.

Reset
REQ-031 With rst high at a posedge, the block SHALL enter IDLE and clear all latched registers to 0.
REQ-032 While rst=1: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
REQ-033 A reset during any state SHALL abandon the request with no response; dmem_we SHALL be gated low in the reset cycle, so a write never occurs.

Structure
REQ-034 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the ADDR_W default.
REQ-035 Lane extraction/extension and lane merge SHALL live in one combinational sub-module, dmem_lane_align; the FSM and registers stay in dmem_lsu.

Verification
REQ-036 Word store then load: store addr 0x10, data 0xDEADBEEF; then load word 0x10 -> dmem_we pulse with dmem_addr 4; load resp_rdata 0xDEADBEEF, 2-cycle latency each.
REQ-037 Byte RMW: word 4 = 0x11223344; store byte 0x13, data 0xAA -> one write, dmem_wdata 0xAA223344; a signed lb at 0x13 then returns 0xFFFFFFAA.
REQ-038 Half load: word 4 = 0x8001_7FFF; unsigned lh 0x12 -> 0x00008001; signed lh 0x12 -> 0xFFFF8001; signed lh 0x10 -> 0x00007FFF.
REQ-039 Errors: lw at 0x11, lh at 0x13, size 11, and addr 0x2000 -> resp_err=1 after 1 cycle, resp_rdata 0, no dmem_we.
REQ-040 Reset mid-op: assert rst during the WRITE cycle of sb 0x20 -> no dmem_we, no resp_valid; req_ready returns to 1 in the first cycle after rst deasserts.
REQ-041 Back-to-back: hold req_valid high with 3 loads -> each accepted only in IDLE, 3 responses in order, never two in flight.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: size encodings,
// FSM state type, default word-index width and the alignment/size check.
package dmem_lsu_pkg;

    localparam int ADDR_W_DEFAULT = 11;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // True when the size code is illegal or the low address bits do not
    // match the natural alignment of the access. The range check depends
    // on the memory size, so it is done by the caller.
    function automatic logic size_align_bad(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU; the master modport is the pipeline plus
// the memory array that sits on the other side.
interface dmem_lsu_if
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dmem_we, dmem_addr, dmem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dmem_we, dmem_addr, dmem_wdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: extracts and extends the addressed byte/half
// of a read word for loads, and merges store data into a previously read
// word for sub-word stores. Purely combinational.
module dmem_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_base,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load = i_rdata;
            default: o_load = 32'd0;
        endcase
    end

    // Replace only the addressed lane of the base word with store data.
    always_comb begin
        o_merged = i_base;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
            end
            SZ_WORD: o_merged = i_wdata;
            default: o_merged = i_base;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit. Accepts one request at a time, performs a
// read, a write or a read-modify-write on a single-port word memory, and
// returns a one-cycle response pulse. Bad requests never touch memory.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
)(
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;

    logic              r_write;
    logic              r_signed;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_index;
    logic [31:0]       r_wdata;
    logic [31:0]       r_base;
    logic [31:0]       r_result;

    logic              w_ready;
    logic              w_accept;
    logic              w_range_err;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_ready     = (r_state == ST_IDLE) && !rst;
    assign w_accept    = bus.req_valid && w_ready;
    assign w_range_err = ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_err       = size_align_bad(bus.req_size, bus.req_addr[1:0]) || w_range_err;

    dmem_lane_align u_align (
        .i_rdata  (bus.dmem_rdata),
        .i_base   (r_base),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_lane   (r_lane),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Next-state selection and all outputs; everything is forced low in reset
    // so an in-progress write is dropped in the reset cycle.
    always_comb begin
        w_next          = r_state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_err    = 1'b0;
        bus.resp_rdata  = 32'd0;
        bus.dmem_we     = 1'b0;
        bus.dmem_addr   = '0;
        bus.dmem_wdata  = 32'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = ST_RESP;
                    else if (bus.req_write && (bus.req_size == SZ_WORD))
                        w_next = ST_WRITE;
                    else
                        w_next = ST_READ;
                end
            end
            ST_READ:  w_next = r_write ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase

        if (!rst) begin
            bus.req_ready  = w_ready;
            bus.resp_valid = (r_state == ST_RESP);
            bus.resp_err   = (r_state == ST_RESP) && r_err;
            bus.resp_rdata = (r_state == ST_RESP) ? r_result : 32'd0;
            bus.dmem_we    = (r_state == ST_WRITE);
            bus.dmem_addr  = r_index;
            bus.dmem_wdata = w_merged;
        end
    end

    // State register, request latch on acceptance, and capture of read data
    // (load result, or the base word for a sub-word store).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'b00;
            r_lane   <= 2'b00;
            r_index  <= '0;
            r_wdata  <= 32'd0;
            r_base   <= 32'd0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_signed <= bus.req_signed;
                r_err    <= w_err;
                r_size   <= bus.req_size;
                r_lane   <= bus.req_addr[1:0];
                r_index  <= bus.req_addr[ADDR_W+1:2];
                r_wdata  <= bus.req_wdata;
                r_result <= 32'd0;
            end
            if (r_state == ST_READ) begin
                if (r_write) r_base   <= bus.dmem_rdata;
                else         r_result <= w_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus random traffic, a memory
// array behind the dmem port, and a scoreboard fed by a reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          accCyc;
        int          lat;
    } resp_t;

    typedef struct {
        logic [AW-1:0] idx;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0]   mem    [DEPTH];
    logic [31:0]   refMem [DEPTH];
    logic          plEn;
    logic [AW-1:0] plIdx;
    logic [31:0]   plVal;
    logic [AW-1:0] lastIdx;

    resp_t respQ[$];
    wr_t   wrQ[$];

    dmem_lsu_if #(.ADDR_W(AW)) bus ();

    dmem_lsu #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory array: combinational read, write on the strobe, preload port for the bench.
    assign bus.dmem_rdata = mem[bus.dmem_addr];
    always @(posedge clk) begin
        if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
        else if (plEn)   mem[plIdx] <= plVal;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derives response, latency and memory update from the access rules.
    task automatic modelRequest(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd, input int acc);
        resp_t       r;
        wr_t         wr;
        int          idx;
        int          lane;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        int          sh;
        r.accCyc = acc;
        r.rdata  = 32'd0;
        r.err    = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
                   (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        idx  = int'(addr / 4) % DEPTH;
        lane = int'(addr % 4);
        if (r.err) begin
            r.lat = 1;
        end else if (!w) begin
            r.lat = 2;
            word  = refMem[idx];
            if (sz == 2'd2) begin
                r.rdata = word;
            end else if (sz == 2'd0) begin
                v = (word >> (8 * lane)) & 32'hFF;
                if (sg && v >= 128) v = v - 32'd256;
                r.rdata = v;
            end else begin
                v = (word >> (16 * (lane / 2))) & 32'hFFFF;
                if (sg && v >= 32768) v = v - 32'd65536;
                r.rdata = v;
            end
        end else begin
            r.lat = (sz == 2'd2) ? 2 : 3;
            word  = refMem[idx];
            if (sz == 2'd2) begin
                word = wd;
            end else begin
                sh   = (sz == 2'd0) ? 8 * lane : 16 * (lane / 2);
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                word = (word & ~mask) | ((wd << sh) & mask);
            end
            refMem[idx] = word;
            wr.idx  = AW'(idx);
            wr.data = word;
            wrQ.push_back(wr);
        end
        respQ.push_back(r);
    endtask

    // Present one request, wait (bounded) for acceptance, record the expectation.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input bit hold, input bit doCheck);
        bit acc;
        acc = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                acc = 1;
                checkOutput("one_in_flight", 32'(respQ.size()), 32'd0);
                if (doCheck) modelRequest(w, sz, sg, addr, wd, cyc);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            lastIdx = addr[AW+1:2];
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        plEn  = 1'b1;
        plIdx = AW'(idx);
        plVal = val;
        refMem[idx] = val;
        @(posedge clk);
        #1;
        plEn = 1'b0;
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 30; n++) begin
            if (respQ.size() == 0 && wrQ.size() == 0 && !bus.req_valid) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        lastIdx = '0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every response/write and checks idle-time values.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checkOutput("rst_ctrl", {28'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.dmem_we}, 32'd0);
            checkOutput("rst_rdata", bus.resp_rdata, 32'd0);
            checkOutput("rst_daddr", 32'(bus.dmem_addr), 32'd0);
            checkOutput("rst_wdata", bus.dmem_wdata, 32'd0);
        end else if (rst === 1'b0) begin
            if (bus.resp_valid === 1'b1) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = respQ.pop_front();
                    checkOutput("resp_err", 32'(bus.resp_err), 32'(e.err));
                    checkOutput("resp_rdata", bus.resp_rdata, e.rdata);
                    checkOutput("resp_latency", 32'(cyc - e.accCyc), 32'(e.lat));
                end
            end else begin
                checkOutput("idle_resp_zero", {31'd0, bus.resp_err} | bus.resp_rdata, 32'd0);
            end
            if (bus.dmem_we === 1'b1) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t x;
                    x = wrQ.pop_front();
                    checkOutput("write_addr", 32'(bus.dmem_addr), 32'(x.idx));
                    checkOutput("write_data", bus.dmem_wdata, x.data);
                end
            end
            checkOutput("dmem_addr_hold", 32'(bus.dmem_addr), 32'(lastIdx));
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Stimulus sequence: reset, directed scenarios, random traffic, drain.
    initial begin
        logic [31:0] keep8;
        rst = 1'b1;
        plEn = 1'b0; plIdx = '0; plVal = 32'd0;
        lastIdx = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        doReset(2);
        for (int i = 0; i < 16; i++) preload(i, $urandom);

        $display("[TB] word store then load");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, 1);
        waitIdle();
        checkOutput("mem_word4_sw", mem[4], 32'hDEADBEEF);

        $display("[TB] byte read-modify-write");
        preload(4, 32'h11223344);
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h000000AA, 0, 1);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 0, 1);
        waitIdle();
        checkOutput("mem_word4_sb", mem[4], 32'hAA223344);

        $display("[TB] half loads");
        preload(4, 32'h80017FFF);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 0, 1);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 0, 1);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 0, 1);

        $display("[TB] error requests");
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 0, 1);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 0, 1);
        applyStimulus(1'b1, SZ_ILLEGAL, 1'b0, 32'h10, 32'h12345678, 0, 1);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h2000, 32'h0, 0, 1);
        applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h2002, 32'h0000BEEF, 0, 1);
        waitIdle();

        $display("[TB] reset during write");
        keep8 = 32'h5A5AC3C3;
        preload(8, keep8);
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h00000055, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lastIdx = '0;
        @(negedge clk);
        checkOutput("ready_after_midop_rst", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("mem_word8_kept", mem[8], keep8);

        $display("[TB] back-to-back loads");
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1, 1);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h7, 32'h0, 1, 1);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 0, 1);
        waitIdle();

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [1:0]  sz;
            logic        sg;
            logic [31:0] addr;
            int          r;
            bit          hold;
            w    = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 7);
            sz   = (r < 7) ? 2'(r % 3) : SZ_ILLEGAL;
            sg   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h2000) : 32'($urandom_range(0, 63));
            hold = ($urandom_range(0, 2) == 0);
            applyStimulus(w, sz, sg, addr, $urandom, hold, 1);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.req_valid = 1'b0;
        waitIdle();
        repeat (3) @(posedge clk);
        checkOutput("drain_resp", 32'(respQ.size()), 32'd0);
        checkOutput("drain_write", 32'(wrQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
